// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative radix-2 MULU/MULS/DIVU/DIVS unit with XNZVC flags.
// Define ALU_MULDIV_EARLY_OUT_EN to end multiplies early when the multiplier runs out of ones.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_result_hi,
  output logic [4:0]       out_xnzvc,
  output logic             out_divz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 x_q, x_d;
  logic                 negp_q, negp_d;
  logic                 negr_q, negr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [4:0]           flags_q, flags_d;
  logic                 divz_q, divz_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 is_div, last, ge, v;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_sub;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  always_comb begin
    a_neg = in_op[0] & in_a[WIDTH-1];
    b_neg = in_op[0] & in_b[WIDTH-1];
    a_mag = a_neg ? -in_a : in_a;
    b_mag = b_neg ? -in_b : in_b;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    negp_d   = negp_q;
    negr_d   = negr_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    divz_d   = divz_q;

    is_div  = op_q[1];
    // Restoring division: acc low half is the partial remainder,
    // mplier shifts the dividend out and the quotient in.
    rem_sh  = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
    ge      = rem_sh >= {1'b0, mcand_q[WIDTH-1:0]};
    rem_sub = rem_sh[WIDTH-1:0] - mcand_q[WIDTH-1:0];
`ifdef ALU_MULDIV_EARLY_OUT_EN
    last = (cnt_q == CW'(WIDTH-1))
         | (~is_div & (mplier_q[WIDTH-1:1] == '0));
`else
    last = cnt_q == CW'(WIDTH-1);
`endif

    prod = negp_q ? -acc_q : acc_q;
    quo  = negp_q ? -mplier_q : mplier_q;
    rem  = negr_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    if (is_div) begin
      // Only MIN/-1 leaves an unrepresentable positive 2^(WIDTH-1).
      v = op_q[0] & ~negp_q & mplier_q[WIDTH-1];
    end else if (op_q[0]) begin
      v = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    end else begin
      v = prod[2*WIDTH-1:WIDTH] != '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d   = in_op;
          x_d    = in_x;
          cnt_d  = '0;
          negp_d = a_neg ^ b_neg;
          negr_d = a_neg;
          divz_d = 1'b0;
          if (in_op[1] && in_b == '0) begin
            state_d = S_DONE;
            lo_d    = '0;
            hi_d    = in_a;
            flags_d = {in_x, 4'b0000};
            divz_d  = 1'b1;
          end else begin
            state_d  = S_RUN;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, in_op[1] ? b_mag : a_mag};
            mplier_d = in_op[1] ? a_mag : b_mag;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div) begin
          acc_d    = {{WIDTH{1'b0}}, ge ? rem_sub : rem_sh[WIDTH-1:0]};
          mplier_d = {mplier_q[WIDTH-2:0], ge};
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (last) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_div) begin
          lo_d    = quo;
          hi_d    = rem;
          flags_d = {x_q, quo[WIDTH-1], quo == '0, v, 1'b0};
        end else begin
          lo_d    = prod[WIDTH-1:0];
          hi_d    = prod[2*WIDTH-1:WIDTH];
          flags_d = {x_q, prod[WIDTH-1], prod == '0, v, 1'b0};
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      x_q      <= 1'b0;
      negp_q   <= 1'b0;
      negr_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      negp_q   <= negp_d;
      negr_q   <= negr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      divz_q   <= divz_d;
    end
  end

  assign in_ready      = state_q == S_IDLE;
  assign out_valid     = state_q == S_DONE;
  assign out_result    = lo_q;
  assign out_result_hi = hi_q;
  assign out_xnzvc     = flags_q;
  assign out_divz      = divz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vector table plus handshake/reset sequences.
// Latency is counted with the accept edge as edge 1.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_result_hi;
  logic [4:0]  out_xnzvc;
  logic        out_divz;

  int checks = 0;
  int failures = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_a(in_a),
    .in_b(in_b),
    .in_x(in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_result_hi(out_result_hi),
    .out_xnzvc(out_xnzvc),
    .out_divz(out_divz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        x;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [4:0]  f;
    logic        dz;
    int          lat_fx;
    int          lat_eo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic x);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_x     = x;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic take;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int exp_lat;
    string nm;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
                 32'h00000001, 32'hFFFFFFFE, 5'b00010, 1'b0, 34, 34};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 1'b1,
                 32'hFFFFFFF1, 32'hFFFFFFFF, 5'b11000, 1'b0, 34, 5};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 1'b0,
                 32'hFFFFFFFD, 32'hFFFFFFFF, 5'b01000, 1'b0, 34, 34};
    vecs[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0,
                 32'h80000000, 32'h00000000, 5'b01010, 1'b0, 34, 34};
    vecs[4]  = '{2'b10, 32'd100, 32'd0, 1'b1,
                 32'h00000000, 32'h00000064, 5'b10000, 1'b1, 1, 1};
    vecs[5]  = '{2'b00, 32'd7, 32'd3, 1'b0,
                 32'h00000015, 32'h00000000, 5'b00000, 1'b0, 34, 4};
    vecs[6]  = '{2'b00, 32'd0, 32'd5, 1'b0,
                 32'h00000000, 32'h00000000, 5'b00100, 1'b0, 34, 5};
    vecs[7]  = '{2'b10, 32'd100, 32'd7, 1'b0,
                 32'h0000000E, 32'h00000002, 5'b00000, 1'b0, 34, 34};
    vecs[8]  = '{2'b10, 32'd5, 32'd10, 1'b1,
                 32'h00000000, 32'h00000005, 5'b10100, 1'b0, 34, 34};
    vecs[9]  = '{2'b01, 32'h40000000, 32'd2, 1'b0,
                 32'h80000000, 32'h00000000, 5'b01010, 1'b0, 34, 4};
    vecs[10] = '{2'b11, 32'd7, 32'hFFFFFFFE, 1'b0,
                 32'hFFFFFFFD, 32'h00000001, 5'b01000, 1'b0, 34, 34};
    vecs[11] = '{2'b11, 32'hFFFFFFF8, 32'd0, 1'b0,
                 32'h00000000, 32'hFFFFFFF8, 5'b00000, 1'b1, 1, 1};
    vecs[12] = '{2'b01, 32'h80000000, 32'h80000000, 1'b0,
                 32'h00000000, 32'h40000000, 5'b00010, 1'b0, 34, 34};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_x      = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outs", {out_result, out_result_hi}, 64'd0);
    chk("rst_flags", {58'd0, out_xnzvc, out_divz}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
`ifdef ALU_MULDIV_EARLY_OUT_EN
      exp_lat = vecs[i].lat_eo;
`else
      exp_lat = vecs[i].lat_fx;
`endif
      start(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].x);
      wait_valid(lat);
      nm = $sformatf("v%0d", i);
      chk({nm, "_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({nm, "_lo"}, 64'(out_result), 64'(vecs[i].lo));
      chk({nm, "_hi"}, 64'(out_result_hi), 64'(vecs[i].hi));
      chk({nm, "_xnzvc"}, 64'(out_xnzvc), 64'(vecs[i].f));
      chk({nm, "_divz"}, 64'(out_divz), 64'(vecs[i].dz));
      take();
      chk({nm, "_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
    end

    // Back-pressure: result must hold and no new accept while DONE.
    start(2'b00, 32'd7, 32'd3, 1'b1);
    wait_valid(lat);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {62'd0, out_valid, in_ready}, 64'd2);
      chk("bp_lo", {out_result_hi, out_result}, 64'h15);
      chk("bp_flags", 64'(out_xnzvc), 64'(5'b10000));
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 2'b10;
    in_a      = 32'd9;
    in_b      = 32'd0;
    in_x      = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("take_to_idle", {62'd0, in_ready, out_valid}, 64'd2);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("accept_after_take", {62'd0, out_valid, out_divz}, 64'd3);
    chk("accept_after_take_r", 64'(out_result_hi), 64'd9);
    take();

    // Reset mid-RUN discards the in-flight op.
    start(2'b10, 32'd1000, 32'd3, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_outs", {out_result, out_result_hi}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_result", {62'd0, out_valid, in_ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
